ysyx_22040632_lsu: RTL and testbench
====================================

Name: ysyx_22040632_lsu

Overview:
- Memory stage of the 5-stage RV64 core, directly downstream of the execute stage.
- Consumes the registered execute-to-memory bundle: ld/sd enables, load/store type, effective address, store data, rd, write enable.
- Performs the data-bus transaction with a req/gnt/rvalid handshake, aligns and extends load data, and builds byte strobes for stores.
- Drives the memory-to-writeback register, mem_busy back to execute, and the 1-cycle and 2-cycle load-forwarding taps used by execute hazard logic.

Parameters:
- ADDR_W, 32, data-bus address width.
- DATA_W, 64, data-bus and GPR width.

Ports:
- clk  in  1  clock
- rrst_n  in  1  reset, asynchronous, active-low
- ld_en  in  1  execute-stage load valid
- sd_en  in  1  execute-stage store valid
- ld_ty  in  3  load type (pkg enum)
- sd_ty  in  2  store type (pkg enum)
- addr  in  64  effective address (execute data2mem); [31:0] used
- sdata  in  64  store data (execute data_ext2mem)
- rd  in  5  destination register
- rd_w_ena  in  1  execute write enable
- mem_busy  out  1  stall to execute
- bus_req  out  1  bus request
- bus_we  out  1  1 = write
- bus_addr  out  32  8-byte aligned address
- bus_wdata  out  64  lane-shifted store data
- bus_wstrb  out  8  byte strobes
- bus_gnt  in  1  request accepted
- bus_rvalid  in  1  response valid (loads and stores)
- bus_rdata  in  64  read data
- lden_1cy  out  1  load result valid this cycle
- data_ld_1cy  out  64  extended load result
- lden_2cy  out  1  lden_1cy delayed one cycle
- rd_2cy  out  5  rd of the 2cy load
- data_ld_2cy  out  64  data_ld_1cy delayed one cycle
- rd_w_ena2wb  out  1  writeback enable
- rd2wb  out  5  writeback rd
- data2wb  out  64  writeback data
- misalign  out  1  1-cycle pulse, access crossed its natural alignment

Behaviour:
- Reset values: every output register clears to 0; FSM goes to IDLE; bus_req is 0.
- FSM states: IDLE, REQ, RESP.
- IDLE
  - If ld_en or sd_en and the access is aligned: assert bus_req combinationally and go to REQ; if bus_gnt is already high this cycle, go straight to RESP.
  - If the access is misaligned (ld/sd halfword with addr[0]=1, word with addr[1:0]≠0, double with addr[2:0]≠0): pulse misalign, issue no bus request, write nothing back, stay in IDLE.
- REQ: hold bus_req and all bus_* fields stable until bus_gnt, then go to RESP.
- RESP
  - Wait for bus_rvalid.
  - Load: extract the lane at addr[2:0] (byte, half, word, or double), sign- or zero-extend per ld_ty, register it into data_ld_1cy, pulse lden_1cy, write rd2wb/data2wb with rd_w_ena2wb=1.
  - Store: no writeback.
  - Return to IDLE.
- bus_rvalid in the same cycle as gnt is illegal; the bench never drives it.
- mem_busy = (state≠IDLE) or (IDLE and a request is being issued this cycle). It falls in the cycle after rvalid is accepted.
- Capture: addr, ld_ty, sd_ty, sdata, and rd are latched on leaving IDLE. Execute also holds its bundle while busy, but the LSU uses only its latched copy.
- Non-memory op (ld_en=sd_en=0): writeback register loads rd_w_ena/rd/addr (ALU result) every cycle, 1-cycle latency, no FSM involvement.
- While the FSM is not IDLE, the writeback register writes rd_w_ena2wb=0 except in the load-completion cycle.
- Store strobes, with off = addr[2:0]:
  - sb: 1<<off
  - sh: 3<<off
  - sw: 0x0F<<off
  - sd: 0xFF
  - bus_wdata = sdata << (8·off)
  - bus_we=1.
- Load: bus_we=0, bus_wstrb=0.
- 2cy tap: lden_2cy, rd_2cy, and data_ld_2cy register the 1cy tap and rd every cycle.
- rd=0 loads still perform the bus access but force rd_w_ena2wb=0 and lden_1cy=0.
- Reset asserted mid-transaction: immediate return to IDLE, bus_req drops asynchronously, and a late bus_rvalid after release is ignored in IDLE.
- bus_rvalid arriving in IDLE or REQ is ignored.

Decomposition:
- Shared package holds:
  - load type enum {lwt, lwut, ldt, lbut, lbt, lht, lhut}
  - store type enum {sdt, sbt, swt, sht}
  - LSU FSM state enum.
- One natural sub-module: ysyx_22040632_ld_align, purely combinational (rdata, offset, ld_ty → extended 64-bit result), also reused for strobe and shift generation via a store-mode input.

Test Plan:
- lb at addr 0x8000_0003, bus_rdata 0x0000_0000_8000_0000_0000_0000_0000_0000 not applicable; use rdata=0x1122_3344_5566_7788 → data2wb = 0x0000_0000_0000_0055 with rd_w_ena2wb=1; with byte 0xF0 at lane 3 → 0xFFFF_FFFF_FFFF_FFF0.
- sh at addr 0x8000_0006, sdata 0xABCD → bus_wstrb=0xC0, bus_wdata=0xABCD_0000_0000_0000, bus_we=1; no writeback.
- gnt held low 3 cycles, rvalid 2 cycles after gnt → bus_req/bus_addr stable throughout; mem_busy high from issue through rvalid; lden_1cy 1-cycle pulse, lden_2cy follows 1 cycle later with the same data and rd.
- lw at 0x8000_0002 → misalign pulse, bus_req stays 0, no writeback, mem_busy stays 0.
- Reset asserted while in RESP, then rvalid after release → all outputs 0, FSM IDLE, no writeback.
- Back-to-back: add x5 result 0x10, then ld x6 → cycle 1: wb x5=0x10; ld completion: wb x6 with loaded value; no lost or duplicate writebacks.

Source files
------------

// File: rtl/ysyx_22040632_lsu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ysyx_22040632_lsu_pkg                                              |
// | Shared load/store type encodings and LSU FSM states.              |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package ysyx_22040632_lsu_pkg;

  typedef enum logic [2:0] {
    lwt  = 3'd0,
    lwut = 3'd1,
    ldt  = 3'd2,
    lbut = 3'd3,
    lbt  = 3'd4,
    lht  = 3'd5,
    lhut = 3'd6
  } ld_ty_e;

  typedef enum logic [1:0] {
    sdt = 2'd0,
    sbt = 2'd1,
    swt = 2'd2,
    sht = 2'd3
  } sd_ty_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } lsu_state_e;

  // Loads take priority when both enables are set, matching bus_we selection.
  function automatic logic is_misaligned(input logic ld, input logic [2:0] lty,
                                         input logic [1:0] sty, input logic [2:0] off);
    logic [2:0] mask;
    mask = 3'b000;
    if (ld) begin
      case (ld_ty_e'(lty))
        lht, lhut: mask = 3'b001;
        lwt, lwut: mask = 3'b011;
        ldt:       mask = 3'b111;
        default:   mask = 3'b000;
      endcase
    end else begin
      case (sd_ty_e'(sty))
        sht:     mask = 3'b001;
        swt:     mask = 3'b011;
        sdt:     mask = 3'b111;
        default: mask = 3'b000;
      endcase
    end
    return |(off & mask);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22040632_ld_align.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ysyx_22040632_ld_align                                             |
// | Lane extraction/extension for loads; lane shift and strobes for   |
// | stores when store_mode is set. Purely combinational.              |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module ysyx_22040632_ld_align
  import ysyx_22040632_lsu_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0]   rdata,
  input  logic [2:0]          offset,
  input  logic [2:0]          ld_ty,
  input  logic [1:0]          sd_ty,
  input  logic                store_mode,
  output logic [DATA_W-1:0]   result,
  output logic [DATA_W/8-1:0] wstrb
);

  logic [5:0]        w_shamt;
  logic [DATA_W-1:0] w_lane;

  always_comb begin
    w_shamt = {offset, 3'b000};
    w_lane  = rdata >> w_shamt;
    result  = '0;
    wstrb   = '0;
    if (store_mode) begin
      result = rdata << w_shamt;
      case (sd_ty_e'(sd_ty))
        sbt:     wstrb = 8'h01 << offset;
        sht:     wstrb = 8'h03 << offset;
        swt:     wstrb = 8'h0F << offset;
        default: wstrb = '1;
      endcase
    end else begin
      case (ld_ty_e'(ld_ty))
        lbt:     result = {{(DATA_W-8){w_lane[7]}}, w_lane[7:0]};
        lbut:    result = {{(DATA_W-8){1'b0}}, w_lane[7:0]};
        lht:     result = {{(DATA_W-16){w_lane[15]}}, w_lane[15:0]};
        lhut:    result = {{(DATA_W-16){1'b0}}, w_lane[15:0]};
        lwt:     result = {{(DATA_W-32){w_lane[31]}}, w_lane[31:0]};
        lwut:    result = {{(DATA_W-32){1'b0}}, w_lane[31:0]};
        default: result = w_lane;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ysyx_22040632_lsu.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ysyx_22040632_lsu                                                  |
// | Memory stage: req/gnt/rvalid data-bus master, MEM/WB register and  |
// | load-forwarding taps for execute.                                  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module ysyx_22040632_lsu
  import ysyx_22040632_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rrst_n,
  input  logic                ld_en,
  input  logic                sd_en,
  input  logic [2:0]          ld_ty,
  input  logic [1:0]          sd_ty,
  input  logic [63:0]         addr,
  input  logic [DATA_W-1:0]   sdata,
  input  logic [4:0]          rd,
  input  logic                rd_w_ena,
  output logic                mem_busy,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_wstrb,
  input  logic                bus_gnt,
  input  logic                bus_rvalid,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                lden_1cy,
  output logic [DATA_W-1:0]   data_ld_1cy,
  output logic                lden_2cy,
  output logic [4:0]          rd_2cy,
  output logic [DATA_W-1:0]   data_ld_2cy,
  output logic                rd_w_ena2wb,
  output logic [4:0]          rd2wb,
  output logic [DATA_W-1:0]   data2wb,
  output logic                misalign
);

  lsu_state_e          r_state, w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_ld;
  logic [2:0]          r_ld_ty;
  logic [1:0]          r_sd_ty;
  logic [DATA_W-1:0]   r_sdata;
  logic [4:0]          r_rd;

  logic                w_mem_op, w_mis, w_issue, w_idle;
  logic                w_ld_done, w_ld_wb;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic                w_sel_sd;
  logic [1:0]          w_sel_sty;
  logic [DATA_W-1:0]   w_sel_sdata;
  logic [DATA_W-1:0]   w_st_data, w_ld_data;
  logic [DATA_W/8-1:0] w_st_strb, w_ld_strb;
  logic                w_unused;

  assign w_mem_op  = ld_en | sd_en;
  assign w_mis     = w_mem_op & is_misaligned(ld_en, ld_ty, sd_ty, addr[2:0]);
  assign w_issue   = w_mem_op & ~w_mis;
  assign w_idle    = (r_state == S_IDLE);
  assign w_ld_done = (r_state == S_RESP) & bus_rvalid & r_ld;
  assign w_ld_wb   = w_ld_done & (|r_rd);
  assign w_unused  = ^{addr[63:ADDR_W], w_ld_strb};

  // In IDLE the request is issued straight from the execute bundle; afterwards
  // only the latched copy drives the bus so fields stay stable until grant.
  assign w_sel_addr  = w_idle ? addr[ADDR_W-1:0] : r_addr;
  assign w_sel_sd    = w_idle ? (sd_en & ~ld_en) : ~r_ld;
  assign w_sel_sty   = w_idle ? sd_ty : r_sd_ty;
  assign w_sel_sdata = w_idle ? sdata : r_sdata;

  ysyx_22040632_ld_align #(.DATA_W(DATA_W)) u_st_align (
    .rdata      (w_sel_sdata),
    .offset     (w_sel_addr[2:0]),
    .ld_ty      (r_ld_ty),
    .sd_ty      (w_sel_sty),
    .store_mode (1'b1),
    .result     (w_st_data),
    .wstrb      (w_st_strb)
  );

  ysyx_22040632_ld_align #(.DATA_W(DATA_W)) u_ld_align (
    .rdata      (bus_rdata),
    .offset     (r_addr[2:0]),
    .ld_ty      (r_ld_ty),
    .sd_ty      (r_sd_ty),
    .store_mode (1'b0),
    .result     (w_ld_data),
    .wstrb      (w_ld_strb)
  );

  assign bus_we    = w_sel_sd;
  assign bus_addr  = {w_sel_addr[ADDR_W-1:3], 3'b000};
  assign bus_wdata = w_sel_sd ? w_st_data : '0;
  assign bus_wstrb = w_sel_sd ? w_st_strb : '0;

  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // rrst_n gating lets bus_req and mem_busy drop the instant reset asserts.
  always_comb begin
    w_next   = r_state;
    bus_req  = 1'b0;
    mem_busy = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus_req  = w_issue & rrst_n;
        mem_busy = w_issue & rrst_n;
        if (w_issue) w_next = bus_gnt ? S_RESP : S_REQ;
      end
      S_REQ: begin
        bus_req  = rrst_n;
        mem_busy = rrst_n;
        if (bus_gnt) w_next = S_RESP;
      end
      S_RESP: begin
        mem_busy = rrst_n;
        if (bus_rvalid) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_addr  <= '0;
      r_ld    <= 1'b0;
      r_ld_ty <= '0;
      r_sd_ty <= '0;
      r_sdata <= '0;
      r_rd    <= '0;
    end else if (w_idle && w_issue) begin
      r_addr  <= addr[ADDR_W-1:0];
      r_ld    <= ld_en;
      r_ld_ty <= ld_ty;
      r_sd_ty <= sd_ty;
      r_sdata <= sdata;
      r_rd    <= rd;
    end
  end

  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) begin
      rd_w_ena2wb <= 1'b0;
      rd2wb       <= '0;
      data2wb     <= '0;
      misalign    <= 1'b0;
      lden_1cy    <= 1'b0;
      data_ld_1cy <= '0;
      lden_2cy    <= 1'b0;
      rd_2cy      <= '0;
      data_ld_2cy <= '0;
    end else begin
      if (w_idle) begin
        misalign <= w_mis;
        if (w_mem_op) begin
          rd_w_ena2wb <= 1'b0;
        end else begin
          rd_w_ena2wb <= rd_w_ena;
          rd2wb       <= rd;
          data2wb     <= addr;
        end
      end else begin
        misalign    <= 1'b0;
        rd_w_ena2wb <= w_ld_wb;
        if (w_ld_done) begin
          rd2wb   <= r_rd;
          data2wb <= w_ld_data;
        end
      end
      lden_1cy <= w_ld_wb;
      if (w_ld_done) data_ld_1cy <= w_ld_data;
      // rd2wb holds the load's rd in the cycle lden_1cy is high.
      lden_2cy    <= lden_1cy;
      rd_2cy      <= rd2wb;
      data_ld_2cy <= data_ld_1cy;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040632_lsu.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ysyx_22040632_lsu                                               |
// | Scoreboarded bench for the memory stage.                          |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_ysyx_22040632_lsu;
  import ysyx_22040632_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rrst_n;
  logic        ld_en, sd_en, rd_w_ena;
  logic [2:0]  ld_ty;
  logic [1:0]  sd_ty;
  logic [63:0] addr, sdata;
  logic [4:0]  rd;
  logic        mem_busy, bus_req, bus_we, bus_gnt, bus_rvalid;
  logic [31:0] bus_addr;
  logic [63:0] bus_wdata, bus_rdata;
  logic [7:0]  bus_wstrb;
  logic        lden_1cy, lden_2cy, rd_w_ena2wb, misalign;
  logic [63:0] data_ld_1cy, data_ld_2cy, data2wb;
  logic [4:0]  rd_2cy, rd2wb;

  int          checks = 0;
  int          failures = 0;
  logic [68:0] sb_q[$];

  always #5 clk = ~clk;

  ysyx_22040632_lsu #(.ADDR_W(32), .DATA_W(64)) dut (
    .clk(clk), .rrst_n(rrst_n), .ld_en(ld_en), .sd_en(sd_en), .ld_ty(ld_ty),
    .sd_ty(sd_ty), .addr(addr), .sdata(sdata), .rd(rd), .rd_w_ena(rd_w_ena),
    .mem_busy(mem_busy), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_gnt(bus_gnt),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .lden_1cy(lden_1cy),
    .data_ld_1cy(data_ld_1cy), .lden_2cy(lden_2cy), .rd_2cy(rd_2cy),
    .data_ld_2cy(data_ld_2cy), .rd_w_ena2wb(rd_w_ena2wb), .rd2wb(rd2wb),
    .data2wb(data2wb), .misalign(misalign)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_idle();
    ld_en = 1'b0; sd_en = 1'b0; rd_w_ena = 1'b0; rd = 5'd0;
    ld_ty = 3'd0; sd_ty = 2'd0; addr = 64'h0BAD_0000; sdata = 64'h0;
  endtask

  // Every writeback is compared against the oldest expected entry.
  always @(negedge clk) begin
    if (rrst_n === 1'b1 && rd_w_ena2wb === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_eq("wb_unexpected", {59'h0, rd2wb}, 64'hFFFF);
      end else begin
        logic [68:0] e;
        e = sb_q.pop_front();
        check_eq("wb_rd", {59'h0, rd2wb}, {59'h0, e[68:64]});
        check_eq("wb_data", data2wb, e[63:0]);
      end
    end
  end

  task automatic run_op(input logic is_ld, input logic [2:0] lty, input logic [1:0] sty,
                        input logic [63:0] a, input logic [63:0] sd, input logic [4:0] r,
                        input int gdly, input int rdly, input logic [63:0] rdat,
                        input logic [31:0] exp_addr, input logic [7:0] exp_strb,
                        input logic [63:0] exp_wdata, input logic [63:0] exp_ld);
    logic exp_tap;
    exp_tap = is_ld && (r != 5'd0);
    @(posedge clk); #1;
    ld_en = is_ld; sd_en = !is_ld; ld_ty = lty; sd_ty = sty; addr = a;
    sdata = sd; rd = r; rd_w_ena = 1'b1; bus_gnt = (gdly == 0);
    if (exp_tap) sb_q.push_back({r, exp_ld});
    @(negedge clk);
    check_eq("issue_req", bus_req, 1);
    check_eq("issue_busy", mem_busy, 1);
    check_eq("issue_addr", bus_addr, exp_addr);
    check_eq("issue_we", bus_we, !is_ld);
    check_eq("issue_strb", bus_wstrb, exp_strb);
    check_eq("issue_wdata", bus_wdata, exp_wdata);
    for (int k = 1; k <= gdly; k++) begin
      @(posedge clk); #1;
      drive_idle();
      bus_gnt = (k == gdly); bus_rvalid = (k < gdly); bus_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
      @(negedge clk);
      check_eq("hold_req", bus_req, 1);
      check_eq("hold_busy", mem_busy, 1);
      check_eq("hold_addr", bus_addr, exp_addr);
      check_eq("hold_we", bus_we, !is_ld);
      check_eq("hold_strb", bus_wstrb, exp_strb);
      check_eq("hold_wdata", bus_wdata, exp_wdata);
    end
    for (int j = 1; j <= rdly; j++) begin
      @(posedge clk); #1;
      drive_idle();
      bus_gnt = 1'b0; bus_rvalid = (j == rdly);
      bus_rdata = (j == rdly) ? rdat : 64'hDEAD_DEAD_DEAD_DEAD;
      @(negedge clk);
      check_eq("resp_busy", mem_busy, 1);
      check_eq("resp_req", bus_req, 0);
    end
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    @(negedge clk);
    check_eq("done_busy", mem_busy, 0);
    check_eq("lden_1cy", lden_1cy, exp_tap);
    if (is_ld) check_eq("data_ld_1cy", data_ld_1cy, exp_ld);
    @(negedge clk);
    check_eq("lden_1cy_pulse", lden_1cy, 0);
    check_eq("lden_2cy", lden_2cy, exp_tap);
    if (exp_tap) begin
      check_eq("data_ld_2cy", data_ld_2cy, exp_ld);
      check_eq("rd_2cy", {59'h0, rd_2cy}, {59'h0, r});
    end
  endtask

  task automatic mis_op(input logic is_ld, input logic [2:0] lty, input logic [1:0] sty,
                        input logic [63:0] a);
    @(posedge clk); #1;
    ld_en = is_ld; sd_en = !is_ld; ld_ty = lty; sd_ty = sty; addr = a;
    sdata = 64'h1234; rd = 5'd7; rd_w_ena = 1'b1;
    @(negedge clk);
    check_eq("mis_req", bus_req, 0);
    check_eq("mis_busy", mem_busy, 0);
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    check_eq("mis_pulse", misalign, 1);
    check_eq("mis_nowb", rd_w_ena2wb, 0);
    @(negedge clk);
    check_eq("mis_pulse_end", misalign, 0);
  endtask

  initial begin
    rrst_n = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 64'h0;
    drive_idle();
    repeat (3) @(posedge clk);
    #1 rrst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_req", bus_req, 0);
    check_eq("rst_busy", mem_busy, 0);
    check_eq("rst_lden", lden_1cy, 0);
    check_eq("rst_rd_2cy", {59'h0, rd_2cy}, 0);
    check_eq("rst_misalign", misalign, 0);

    // loads: byte, half, word, double with sign/zero extension
    run_op(1, lbt,  sdt, 64'h8000_0003, 0, 5'd1, 0, 1, 64'h1122_3344_5566_7788,
           32'h8000_0000, 8'h00, 64'h0, 64'h0000_0000_0000_0055);
    run_op(1, lbt,  sdt, 64'h8000_0003, 0, 5'd2, 0, 1, 64'h1122_3344_F066_7788,
           32'h8000_0000, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FFF0);
    run_op(1, lbut, sdt, 64'h8000_0003, 0, 5'd3, 1, 1, 64'h1122_3344_F066_7788,
           32'h8000_0000, 8'h00, 64'h0, 64'h0000_0000_0000_00F0);
    run_op(1, lht,  sdt, 64'h8000_0002, 0, 5'd9, 3, 2, 64'h1122_3344_5566_7788,
           32'h8000_0000, 8'h00, 64'h0, 64'h0000_0000_0000_5566);
    run_op(1, lhut, sdt, 64'h8000_0006, 0, 5'd10, 0, 1, 64'h8001_0000_0000_0000,
           32'h8000_0000, 8'h00, 64'h0, 64'h0000_0000_0000_8001);
    run_op(1, lht,  sdt, 64'h8000_0006, 0, 5'd11, 0, 1, 64'h8001_0000_0000_0000,
           32'h8000_0000, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_8001);
    run_op(1, lwt,  sdt, 64'h8000_0004, 0, 5'd12, 1, 2, 64'h8000_0000_1234_5678,
           32'h8000_0000, 8'h00, 64'h0, 64'hFFFF_FFFF_8000_0000);
    run_op(1, lwut, sdt, 64'h8000_0004, 0, 5'd13, 0, 1, 64'h8000_0000_1234_5678,
           32'h8000_0000, 8'h00, 64'h0, 64'h0000_0000_8000_0000);
    run_op(1, ldt,  sdt, 64'h8000_0008, 0, 5'd14, 0, 1, 64'h0123_4567_89AB_CDEF,
           32'h8000_0008, 8'h00, 64'h0, 64'h0123_4567_89AB_CDEF);
    run_op(1, lwt,  sdt, 64'h8000_0000, 0, 5'd0, 0, 1, 64'h0000_0000_7777_7777,
           32'h8000_0000, 8'h00, 64'h0, 64'h0000_0000_7777_7777);

    // stores: strobes and lane shift, no writeback
    run_op(0, ldt, sht, 64'h8000_0006, 64'hABCD, 5'd15, 0, 1, 64'h0,
           32'h8000_0000, 8'hC0, 64'hABCD_0000_0000_0000, 64'h0);
    run_op(0, ldt, sbt, 64'h8000_0005, 64'h12, 5'd16, 2, 1, 64'h0,
           32'h8000_0000, 8'h20, 64'h0000_1200_0000_0000, 64'h0);
    run_op(0, ldt, swt, 64'h8000_0004, 64'hDEAD_BEEF, 5'd17, 0, 2, 64'h0,
           32'h8000_0000, 8'hF0, 64'hDEAD_BEEF_0000_0000, 64'h0);
    run_op(0, ldt, sdt, 64'h8000_0008, 64'h0102_0304_0506_0708, 5'd18, 1, 1, 64'h0,
           32'h8000_0008, 8'hFF, 64'h0102_0304_0506_0708, 64'h0);

    mis_op(1, lwt, sdt, 64'h8000_0002);
    mis_op(1, lht, sdt, 64'h8000_0001);
    mis_op(0, ldt, sdt, 64'h8000_0004);

    // ALU result immediately followed by a load
    @(posedge clk); #1;
    ld_en = 1'b0; sd_en = 1'b0; rd_w_ena = 1'b1; rd = 5'd5; addr = 64'h10;
    sb_q.push_back({5'd5, 64'h10});
    run_op(1, ldt, sdt, 64'h8000_0020, 0, 5'd6, 0, 1, 64'hCAFE_BABE_1234_5678,
           32'h8000_0020, 8'h00, 64'h0, 64'hCAFE_BABE_1234_5678);

    // reset while in RESP, then a late rvalid
    @(posedge clk); #1;
    ld_en = 1'b1; ld_ty = lwt; addr = 64'h8000_0010; rd = 5'd4; rd_w_ena = 1'b1; bus_gnt = 1'b1;
    @(posedge clk); #1;
    drive_idle(); bus_gnt = 1'b0;
    @(negedge clk);
    check_eq("resp_busy_pre_rst", mem_busy, 1);
    #1 rrst_n = 1'b0;
    #1;
    check_eq("rst_async_busy", mem_busy, 0);
    check_eq("rst_async_req", bus_req, 0);
    check_eq("rst_async_data2wb", data2wb, 0);
    check_eq("rst_async_ld1", data_ld_1cy, 0);
    check_eq("rst_async_ld2", data_ld_2cy, 0);
    @(posedge clk); #1;
    rrst_n = 1'b1; bus_rvalid = 1'b1; bus_rdata = 64'h5555_5555_5555_5555;
    @(negedge clk);
    check_eq("late_rv_busy", mem_busy, 0);
    check_eq("late_rv_req", bus_req, 0);
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    @(negedge clk);
    check_eq("late_rv_wb", rd_w_ena2wb, 0);
    check_eq("late_rv_lden", lden_1cy, 0);
    check_eq("late_rv_busy2", mem_busy, 0);

    repeat (2) @(negedge clk);
    check_eq("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
